// File: rtl/slapfight_rom_loader_if.sv
// ioctl download stream in, per-region ROM write port and load status out.
interface slapfight_rom_loader_if;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic [4:0]  rom_we;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic [19:0] byte_count;
  logic [15:0] checksum;
  logic        rom_ready;
  logic        size_error;
  logic        overflow;

  modport master (
    output dn_download, dn_index, dn_wr, dn_addr, dn_data,
    input  rom_we, rom_addr, rom_data, byte_count, checksum,
           rom_ready, size_error, overflow
  );

  modport slave (
    input  dn_download, dn_index, dn_wr, dn_addr, dn_data,
    output rom_we, rom_addr, rom_data, byte_count, checksum,
           rom_ready, size_error, overflow
  );
endinterface

// File: rtl/slapfight_rom_loader.sv
// Splits the linear index-0 ROM image into region write strobes and tracks
// byte count/checksum so the core can be held in reset until the load is valid.
module slapfight_rom_loader #(
  parameter logic [31:0] MAIN_SZ = 32'h10000,
  parameter logic [31:0] SND_SZ  = 32'h02000,
  parameter logic [31:0] CHR_SZ  = 32'h04000,
  parameter logic [31:0] TIL_SZ  = 32'h20000,
  parameter logic [31:0] SPR_SZ  = 32'h20000
) (
  input logic                  clkm_36MHZ,
  input logic                  RESET_n,
  slapfight_rom_loader_if.slave bus
);

  localparam logic [31:0] SND_BASE = MAIN_SZ;
  localparam logic [31:0] CHR_BASE = SND_BASE + SND_SZ;
  localparam logic [31:0] TIL_BASE = CHR_BASE + CHR_SZ;
  localparam logic [31:0] SPR_BASE = TIL_BASE + TIL_SZ;
  localparam logic [31:0] TOTAL    = SPR_BASE + SPR_SZ;

  typedef enum logic [2:0] {IDLE, LOADING, CHECK, DONE, ERROR} state_t;

  state_t      state;
  logic        dl_q;
  logic        armed;
  logic [4:0]  rom_we;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic [19:0] byte_count;
  logic [15:0] checksum;
  logic        rom_ready;
  logic        size_error;
  logic        overflow;

  logic [31:0] addr_c;
  logic [31:0] region_base_c;
  logic [4:0]  region_we_c;
  logic        write_c;
  logic        accept_c;
  logic        over_c;
  logic        rise_c;
  logic        fall_c;
  logic        start_c;

  assign addr_c = 32'(bus.dn_addr);

  // Strict compares: an address equal to a base belongs to the higher region.
  always_comb begin
    region_we_c   = 5'b00000;
    region_base_c = 32'h0;
    if (addr_c < SND_BASE) begin
      region_we_c   = 5'b00001;
      region_base_c = 32'h0;
    end else if (addr_c < CHR_BASE) begin
      region_we_c   = 5'b00010;
      region_base_c = SND_BASE;
    end else if (addr_c < TIL_BASE) begin
      region_we_c   = 5'b00100;
      region_base_c = CHR_BASE;
    end else if (addr_c < SPR_BASE) begin
      region_we_c   = 5'b01000;
      region_base_c = TIL_BASE;
    end else begin
      region_we_c   = 5'b10000;
      region_base_c = SPR_BASE;
    end
  end

  // armed blocks a download level that is already high at reset release.
  assign rise_c   = bus.dn_download && !dl_q && armed;
  assign fall_c   = !bus.dn_download && dl_q;
  assign start_c  = rise_c && (bus.dn_index == 8'd0) && (state != LOADING);
  assign write_c  = (state == LOADING) && bus.dn_wr && (bus.dn_index == 8'd0);
  assign accept_c = write_c && (addr_c < TOTAL);
  assign over_c   = write_c && !(addr_c < TOTAL);

  always_ff @(posedge clkm_36MHZ or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      armed      <= 1'b0;
      rom_we     <= 5'b00000;
      rom_addr   <= 18'h0;
      rom_data   <= 8'h0;
      byte_count <= 20'h0;
      checksum   <= 16'h0;
      rom_ready  <= 1'b0;
      size_error <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_q   <= bus.dn_download;
      rom_we <= 5'b00000;
      if (!bus.dn_download) begin
        armed <= 1'b1;
      end

      if (start_c) begin
        state      <= LOADING;
        byte_count <= 20'h0;
        checksum   <= 16'h0;
        overflow   <= 1'b0;
        rom_ready  <= 1'b0;
        size_error <= 1'b0;
      end else begin
        case (state)
          LOADING: begin
            if (accept_c) begin
              rom_we   <= region_we_c;
              rom_addr <= 18'(addr_c - region_base_c);
              rom_data <= bus.dn_data;
              checksum <= checksum + 16'(bus.dn_data);
              if (byte_count != 20'hFFFFF) begin
                byte_count <= byte_count + 20'd1;
              end
            end
            if (over_c) begin
              overflow <= 1'b1;
            end
            // A write sharing the falling-edge cycle is still taken above.
            if (fall_c) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if ((32'(byte_count) == TOTAL) && !overflow) begin
              state     <= DONE;
              rom_ready <= 1'b1;
            end else begin
              state      <= ERROR;
              size_error <= 1'b1;
              rom_ready  <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.rom_we     = rom_we;
  assign bus.rom_addr   = rom_addr;
  assign bus.rom_data   = rom_data;
  assign bus.byte_count = byte_count;
  assign bus.checksum   = checksum;
  assign bus.rom_ready  = rom_ready;
  assign bus.size_error = size_error;
  assign bus.overflow   = overflow;

endmodule

// File: tb/tb_slapfight_rom_loader.sv
// Directed bench: a default-size loader for region decode and a scaled-down
// loader (TOTAL 0x560) fed the same stream for complete-load scenarios.
module tb_slapfight_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [24:0] addr;
  logic [7:0]  data;

  int tests = 0;
  int fails = 0;

  slapfight_rom_loader_if bus_big ();
  slapfight_rom_loader_if bus_sm ();

  assign bus_big.dn_download = dl;
  assign bus_big.dn_index    = idx;
  assign bus_big.dn_wr       = wr;
  assign bus_big.dn_addr     = addr;
  assign bus_big.dn_data     = data;
  assign bus_sm.dn_download  = dl;
  assign bus_sm.dn_index     = idx;
  assign bus_sm.dn_wr        = wr;
  assign bus_sm.dn_addr      = addr;
  assign bus_sm.dn_data      = data;

  slapfight_rom_loader u_big (
    .clkm_36MHZ (clk),
    .RESET_n    (rst_n),
    .bus        (bus_big)
  );

  // Bases 0x100/0x120/0x160/0x360, TOTAL 0x560.
  slapfight_rom_loader #(
    .MAIN_SZ (32'h100),
    .SND_SZ  (32'h020),
    .CHR_SZ  (32'h040),
    .TIL_SZ  (32'h200),
    .SPR_SZ  (32'h200)
  ) u_sm (
    .clkm_36MHZ (clk),
    .RESET_n    (rst_n),
    .bus        (bus_sm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    wr   = 1'b1;
    addr = a;
    data = d;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    dl    = 1'b0;
    idx   = 8'd0;
    wr    = 1'b0;
    addr  = '0;
    data  = '0;
    tick();
    tick();
    check("rst_we",    32'(bus_big.rom_we), 32'h0);
    check("rst_addr",  32'(bus_big.rom_addr), 32'h0);
    check("rst_count", 32'(bus_big.byte_count), 32'h0);
    check("rst_flags", {29'd0, bus_big.rom_ready, bus_big.size_error, bus_big.overflow}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Region decode at the default bases.
    dl = 1'b1;
    tick();
    wr_byte(25'h0FFFF, 8'hAA);
    check("main_we",   32'(bus_big.rom_we), 32'h01);
    check("main_addr", 32'(bus_big.rom_addr), 32'hFFFF);
    check("main_data", 32'(bus_big.rom_data), 32'hAA);
    wr_byte(25'h10000, 8'h55);
    check("snd_we",    32'(bus_big.rom_we), 32'h02);
    check("snd_addr",  32'(bus_big.rom_addr), 32'h0);
    check("snd_data",  32'(bus_big.rom_data), 32'h55);
    wr_byte(25'h12000, 8'h11);
    check("chr_we",    32'(bus_big.rom_we), 32'h04);
    check("chr_addr",  32'(bus_big.rom_addr), 32'h0);
    wr_byte(25'h16000, 8'h22);
    check("til_we",    32'(bus_big.rom_we), 32'h08);
    check("til_addr",  32'(bus_big.rom_addr), 32'h0);
    wr_byte(25'h36000, 8'h33);
    check("spr_we",    32'(bus_big.rom_we), 32'h10);
    check("spr_addr",  32'(bus_big.rom_addr), 32'h0);
    wr = 1'b0;
    tick();
    check("idle_we",   32'(bus_big.rom_we), 32'h0);
    check("hold_addr", 32'(bus_big.rom_addr), 32'h0);
    check("hold_data", 32'(bus_big.rom_data), 32'h33);
    check("dec_count", 32'(bus_big.byte_count), 32'h5);
    check("dec_sum",   32'(bus_big.checksum), 32'h165);

    // Non-zero index mid-load is ignored.
    idx = 8'd1;
    wr_byte(25'h0, 8'h99);
    check("idx1_we",    32'(bus_big.rom_we), 32'h0);
    check("idx1_count", 32'(bus_big.byte_count), 32'h5);
    idx = 8'd0;
    wr  = 1'b0;
    dl  = 1'b0;
    tick();
    tick();
    check("short_err",   32'(bus_big.size_error), 32'h1);
    check("short_ready", 32'(bus_big.rom_ready), 32'h0);
    wr_byte(25'h0, 8'h01);
    check("err_wr_we",   32'(bus_big.rom_we), 32'h0);
    wr = 1'b0;

    // Full small load of 0xFF bytes; the last write shares the falling edge.
    dl = 1'b1;
    tick();
    for (int a = 0; a < 32'h55F; a++) begin
      wr_byte(25'(a), 8'hFF);
      if (a == 32'h0FF) begin
        check("sm_main_we", 32'(bus_sm.rom_we), 32'h01);
        check("sm_main_ad", 32'(bus_sm.rom_addr), 32'hFF);
      end
      if (a == 32'h100) check("sm_snd_we", 32'(bus_sm.rom_we), 32'h02);
      if (a == 32'h11F) check("sm_snd_ad", 32'(bus_sm.rom_addr), 32'h1F);
      if (a == 32'h120) check("sm_chr_we", 32'(bus_sm.rom_we), 32'h04);
      if (a == 32'h35F) begin
        check("sm_til_we", 32'(bus_sm.rom_we), 32'h08);
        check("sm_til_ad", 32'(bus_sm.rom_addr), 32'h1FF);
      end
      if (a == 32'h360) check("sm_spr_ad", 32'(bus_sm.rom_addr), 32'h0);
    end
    dl = 1'b0;
    wr_byte(25'h55F, 8'hFF);
    wr = 1'b0;
    check("last_we",    32'(bus_sm.rom_we), 32'h10);
    check("full_count", 32'(bus_sm.byte_count), 32'h560);
    check("full_sum",   32'(bus_sm.checksum), 32'h5AA0);
    check("check_rdy",  32'(bus_sm.rom_ready), 32'h0);
    tick();
    check("full_ready", 32'(bus_sm.rom_ready), 32'h1);
    check("full_err",   32'(bus_sm.size_error), 32'h0);
    check("full_ovf",   32'(bus_sm.overflow), 32'h0);

    // Index-1 download after a good load leaves everything alone.
    idx = 8'd1;
    dl  = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      wr_byte(25'(a), 8'h5A);
      check("dip_we", 32'(bus_sm.rom_we), 32'h0);
    end
    wr = 1'b0;
    dl = 1'b0;
    tick();
    tick();
    check("dip_ready", 32'(bus_sm.rom_ready), 32'h1);
    check("dip_count", 32'(bus_sm.byte_count), 32'h560);
    idx = 8'd0;

    // One byte short.
    dl = 1'b1;
    tick();
    check("start_clr_rdy", 32'(bus_sm.rom_ready), 32'h0);
    check("start_clr_cnt", 32'(bus_sm.byte_count), 32'h0);
    for (int a = 0; a < 32'h55F; a++) wr_byte(25'(a), 8'h01);
    wr = 1'b0;
    dl = 1'b0;
    tick();
    tick();
    check("m1_count", 32'(bus_sm.byte_count), 32'h55F);
    check("m1_sum",   32'(bus_sm.checksum), 32'h55F);
    check("m1_err",   32'(bus_sm.size_error), 32'h1);
    check("m1_ready", 32'(bus_sm.rom_ready), 32'h0);

    // Full load plus one write at TOTAL.
    dl = 1'b1;
    tick();
    for (int a = 0; a < 32'h560; a++) wr_byte(25'(a), 8'h01);
    check("p1_pre_ovf", 32'(bus_sm.overflow), 32'h0);
    wr_byte(25'h560, 8'h01);
    check("p1_we",    32'(bus_sm.rom_we), 32'h0);
    check("p1_ovf",   32'(bus_sm.overflow), 32'h1);
    check("p1_count", 32'(bus_sm.byte_count), 32'h560);
    wr = 1'b0;
    dl = 1'b0;
    tick();
    tick();
    check("p1_err",   32'(bus_sm.size_error), 32'h1);
    check("p1_ready", 32'(bus_sm.rom_ready), 32'h0);

    // Reset mid-load with the download level held high.
    dl = 1'b1;
    tick();
    for (int a = 0; a < 32'h100; a++) wr_byte(25'(a), 8'h02);
    wr = 1'b0;
    check("mid_count", 32'(bus_sm.byte_count), 32'h100);
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(bus_sm.byte_count), 32'h0);
    check("arst_sum",   32'(bus_sm.checksum), 32'h0);
    check("arst_addr",  32'(bus_sm.rom_addr), 32'h0);
    check("arst_flags", {29'd0, bus_sm.rom_ready, bus_sm.size_error, bus_sm.overflow}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      wr_byte(25'(a), 8'h03);
      check("post_rst_we", 32'(bus_sm.rom_we), 32'h0);
    end
    wr = 1'b0;
    check("post_rst_cnt", 32'(bus_sm.byte_count), 32'h0);
    dl = 1'b0;
    tick();
    dl = 1'b1;
    tick();
    wr_byte(25'h0, 8'h7E);
    wr = 1'b0;
    check("fresh_we",   32'(bus_sm.rom_we), 32'h01);
    check("fresh_data", 32'(bus_sm.rom_data), 32'h7E);
    check("fresh_cnt",  32'(bus_sm.byte_count), 32'h1);
    check("fresh_big",  32'(bus_big.rom_we), 32'h01);
    tick();
    check("fresh_pulse", 32'(bus_sm.rom_we), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
